// File: rtl/jk_bank_scheduler_if.sv
// Command/readback bundle between two requesters, the scheduler and one JK register bank.
// master = requesters plus bank readback side, slave = the scheduler.
interface jk_bank_scheduler_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 a_valid;
    logic [1:0]           a_cmd;
    logic [WIDTH-1:0]     a_mask;
    logic                 a_ready;
    logic                 b_valid;
    logic [1:0]           b_cmd;
    logic [WIDTH-1:0]     b_mask;
    logic                 b_ready;
    logic [WIDTH-1:0]     j_out;
    logic [WIDTH-1:0]     k_out;
    logic [WIDTH-1:0]     q_in;
    logic                 busy;
    logic                 done;
    logic                 done_id;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output a_valid, a_cmd, a_mask, b_valid, b_cmd, b_mask, q_in,
        input  a_ready, b_ready, j_out, k_out, busy, done, done_id, err, err_count
    );

    modport slave (
        input  a_valid, a_cmd, a_mask, b_valid, b_cmd, b_mask, q_in,
        output a_ready, b_ready, j_out, k_out, busy, done, done_id, err, err_count
    );
endinterface

// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler for one shared JK bank: grant (T), drive J/K (T+1), verify Q (T+2), report (T+3).
// Ready only in IDLE; nothing is queued, a requester not granted simply retries.
module jk_bank_scheduler #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    jk_bank_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, CHECK = 2'd2} state_t;

    state_t               state_q;
    logic                 rr_q;        // 0: A has priority, 1: B has priority
    logic                 id_q;
    logic [WIDTH-1:0]     j_q, k_q;
    logic [WIDTH-1:0]     exp_q;
    logic                 done_q, done_id_q, err_q;
    logic [ERR_CNT_W-1:0] err_count_q;

    logic                 a_rdy, b_rdy;
    logic [1:0]           sel_cmd;
    logic [WIDTH-1:0]     sel_mask;
    logic [WIDTH-1:0]     j_d, k_d, exp_d;
    logic [ERR_CNT_W-1:0] err_count_d;
    logic                 mismatch;

    assign a_rdy = (state_q == IDLE) & bus.a_valid & (~bus.b_valid | ~rr_q);
    assign b_rdy = (state_q == IDLE) & bus.b_valid & (~bus.a_valid |  rr_q);

    assign sel_cmd  = b_rdy ? bus.b_cmd  : bus.a_cmd;
    assign sel_mask = b_rdy ? bus.b_mask : bus.a_mask;

    // cmd[1] is J, cmd[0] is K; the latched J/K pair is the latched command and mask.
    assign j_d = sel_mask & {WIDTH{sel_cmd[1]}};
    assign k_d = sel_mask & {WIDTH{sel_cmd[0]}};

    // Characteristic JK equation applied to the Q sampled at the handshake.
    assign exp_d = (j_d & ~bus.q_in) | (~k_d & bus.q_in);

    assign mismatch    = (bus.q_in != exp_q);
    assign err_count_d = (&err_count_q) ? err_count_q : err_count_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            id_q        <= 1'b0;
            j_q         <= '0;
            k_q         <= '0;
            exp_q       <= '0;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            j_q    <= '0;
            k_q    <= '0;
            case (state_q)
                IDLE: begin
                    if (a_rdy | b_rdy) begin
                        j_q     <= j_d;
                        k_q     <= k_d;
                        exp_q   <= exp_d;
                        id_q    <= b_rdy;
                        rr_q    <= ~b_rdy;
                        state_q <= APPLY;
                    end
                end
                APPLY: state_q <= CHECK;
                CHECK: begin
                    done_q    <= 1'b1;
                    done_id_q <= id_q;
                    err_q     <= mismatch;
                    if (mismatch) err_count_q <= err_count_d;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.a_ready   = a_rdy;
    assign bus.b_ready   = b_rdy;
    assign bus.j_out     = j_q;
    assign bus.k_out     = k_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Bench for jk_bank_scheduler: behavioural JK bank, directed stimulus, queue scoreboard checked on done.
module tb_jk_bank_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;

    jk_bank_scheduler_if #(.WIDTH(4), .ERR_CNT_W(8)) bus ();

    jk_bank_scheduler #(.WIDTH(4), .ERR_CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [3:0] bank_q   = 4'b0000;
    logic       load_en  = 1'b0;
    logic [3:0] load_val = 4'b0000;
    logic       force_en = 1'b0;

    // External bank: per-bit JK flip-flop, plus a bench preload path.
    always @(posedge clk) begin
        if (load_en) bank_q <= load_val;
        else begin
            for (int i = 0; i < 4; i++) begin
                case ({bus.j_out[i], bus.k_out[i]})
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end
    assign bus.q_in = force_en ? 4'b0000 : bank_q;

    typedef struct {
        logic       id;
        logic [3:0] q;
        logic       err;
        logic       forced;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_cnt     = 0;
    exp_t mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] model(input logic [3:0] q, input logic [1:0] cmd, input logic [3:0] mask);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            if (!mask[i]) r[i] = q[i];
            else case (cmd)
                2'b01:   r[i] = 1'b0;
                2'b10:   r[i] = 1'b1;
                2'b11:   r[i] = ~q[i];
                default: r[i] = q[i];
            endcase
        end
        return r;
    endfunction

    // Scoreboard consumer: every done must match the oldest accepted command.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_cnt = 0;
        end else if (bus.done) begin
            if (sb.size() == 0) chk("spurious_done", {31'd0, bus.done}, 32'd0);
            else begin
                mon_e = sb.pop_front();
                if (mon_e.err && exp_cnt < 255) exp_cnt++;
                chk("done_id", {31'd0, bus.done_id}, {31'd0, mon_e.id});
                chk("err", {31'd0, bus.err}, {31'd0, mon_e.err});
                chk("err_count", {24'd0, bus.err_count}, exp_cnt);
                if (!mon_e.forced) chk("bank_after", {28'd0, bus.q_in}, {28'd0, mon_e.q});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        load_en  = 1'b1;
        load_val = v;
        tick();
        load_en  = 1'b0;
    endtask

    task automatic push_exp(input logic id, input logic [1:0] cmd, input logic [3:0] mask, input logic forced);
        exp_t e;
        e.id     = id;
        e.q      = model(bus.q_in, cmd, mask);
        e.forced = forced;
        e.err    = forced && (e.q != 4'b0000);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_jk", {24'd0, bus.j_out, bus.k_out}, 32'd0);
        chk("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
        chk("rst_err_count", {24'd0, bus.err_count}, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    // One lone-requester transaction, starting and ending just after a rising edge in IDLE.
    task automatic txn(input logic id, input logic [1:0] cmd, input logic [3:0] mask, input logic force_err);
        logic [3:0] jx, kx, qx;
        jx = cmd[1] ? mask : 4'b0000;
        kx = cmd[0] ? mask : 4'b0000;
        if (id) begin bus.b_valid = 1'b1; bus.b_cmd = cmd; bus.b_mask = mask; end
        else    begin bus.a_valid = 1'b1; bus.a_cmd = cmd; bus.a_mask = mask; end
        @(negedge clk);
        chk("grant_ready", {30'd0, bus.b_ready, bus.a_ready}, id ? 32'd2 : 32'd1);
        qx = model(bus.q_in, cmd, mask);
        push_exp(id, cmd, mask, force_err);
        tick();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        chk("apply_j", {28'd0, bus.j_out}, {28'd0, jx});
        chk("apply_k", {28'd0, bus.k_out}, {28'd0, kx});
        chk("apply_busy_ready", {29'd0, bus.busy, bus.b_ready, bus.a_ready}, 32'd4);
        tick();
        force_en = force_err;
        @(negedge clk);
        chk("check_jk", {24'd0, bus.j_out, bus.k_out}, 32'd0);
        if (!force_err) chk("check_q", {28'd0, bus.q_in}, {28'd0, qx});
        tick();
        force_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.a_valid = 1'b0; bus.a_cmd = 2'b00; bus.a_mask = 4'b0000;
        bus.b_valid = 1'b0; bus.b_cmd = 2'b00; bus.b_mask = 4'b0000;

        do_reset();

        // Lone A set on a cleared bank.
        load(4'b0000);
        txn(1'b0, 2'b10, 4'b1111, 1'b0);

        // Both requesters continuously valid: strict alternation from A.
        do_reset();
        load(4'b0000);
        bus.a_valid = 1'b1; bus.a_cmd = 2'b11; bus.a_mask = 4'b0101;
        bus.b_valid = 1'b1; bus.b_cmd = 2'b11; bus.b_mask = 4'b0101;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            chk("rr_grant", {30'd0, bus.b_ready, bus.a_ready}, g[0] ? 32'd2 : 32'd1);
            push_exp(g[0], 2'b11, 4'b0101, 1'b0);
            tick();
            if (g == 3) begin bus.a_valid = 1'b0; bus.b_valid = 1'b0; end
            tick();
            tick();
        end

        // B clears the top bit only.
        load(4'b1010);
        txn(1'b1, 2'b01, 4'b1000, 1'b0);

        // Forced readback mismatches, up to and beyond counter saturation.
        load(4'b0000);
        for (int n = 0; n < 300; n++) txn(1'b0, 2'b10, 4'b1111, 1'b1);
        tick();
        @(negedge clk);
        chk("err_count_sat", {24'd0, bus.err_count}, 32'd255);

        // Reset during APPLY abandons the transaction.
        tick();
        bus.a_valid = 1'b1; bus.a_cmd = 2'b10; bus.a_mask = 4'b1111;
        @(negedge clk);
        chk("abort_grant", {31'd0, bus.a_ready}, 32'd1);
        tick();
        bus.a_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_apply_j", {28'd0, bus.j_out}, 32'hF);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_jk", {24'd0, bus.j_out, bus.k_out}, 32'd0);
        chk("abort_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
        tick();
        @(negedge clk);
        chk("abort_no_done", {31'd0, bus.done}, 32'd0);
        tick();
        bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        @(negedge clk);
        chk("abort_rr_a", {30'd0, bus.b_ready, bus.a_ready}, 32'd1);
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        tick();

        // A pulses while busy with B: ignored, no extra done.
        bus.b_valid = 1'b1; bus.b_cmd = 2'b11; bus.b_mask = 4'b0011;
        @(negedge clk);
        chk("pulse_b_grant", {30'd0, bus.b_ready, bus.a_ready}, 32'd2);
        push_exp(1'b1, 2'b11, 4'b0011, 1'b0);
        tick();
        bus.b_valid = 1'b0;
        bus.a_valid = 1'b1; bus.a_cmd = 2'b10; bus.a_mask = 4'b1111;
        @(negedge clk);
        chk("pulse_a_refused", {31'd0, bus.a_ready}, 32'd0);
        tick();
        bus.a_valid = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("pulse_idle", {31'd0, bus.busy}, 32'd0);
        tick();

        // Empty mask and hold: full sequence, bank unchanged, no error.
        txn(1'b0, 2'b00, 4'b0000, 1'b0);
        txn(1'b0, 2'b00, 4'b1111, 1'b0);

        repeat (3) tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/jk_bank_scheduler.md
Name: jk_bank_scheduler

Overview:
- Shares one bank of WIDTH external JK flip-flops between two requesters, A and B.
- Arbitrates round-robin, translates each granted command into per-bit J/K drive for exactly one clock, then reads back the bank's Q and checks it against the expected value.
- Sits between the command sources and the JK register bank; it is the only driver of the bank's J/K inputs.

Parameters:
- WIDTH, 4: number of JK flip-flops in the bank.
- ERR_CNT_W, 8: width of the saturating mismatch counter.

Ports:
- clk  in  1  rising-edge clock; also clocks the JK bank.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a command.
- a_cmd  in  2  A command: 00 hold, 01 clear (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1).
- a_mask  in  WIDTH  A per-bit enable; a 0 bit drives J=K=0.
- a_ready  out  1  A accepted this cycle.
- b_valid, b_cmd, b_mask, b_ready: identical to the A ports, for requester B.
- j_out  out  WIDTH  J drive to the bank.
- k_out  out  WIDTH  K drive to the bank.
- q_in  in  WIDTH  Q readback from the bank.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  1  requester served (0=A, 1=B); valid with done.
- err  out  1  one-cycle pulse with done when readback mismatches.
- err_count  out  ERR_CNT_W  saturating mismatch count.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE, rr_ptr=A.
- Reset values, all zero: j_out, k_out, done, done_id, err, err_count, busy, latched cmd/mask/expected.
- Reset mid-operation abandons the transaction: no done, J/K forced 0 from the next cycle.
- FSM states: IDLE -> APPLY -> CHECK -> IDLE.
- IDLE, grant rule (combinational ready):
  - a_ready = a_valid & (~b_valid | rr_ptr==A).
  - b_ready = b_valid & (~a_valid | rr_ptr==B).
  - At most one ready is high. Ready is 0 outside IDLE.
- Handshake occurs in cycle T when valid & ready. On that edge:
  - Latch cmd, mask and id.
  - Compute expected per bit from q_in at T: mask=0 or hold -> q; clear -> 0; set -> 1; toggle -> ~q.
  - rr_ptr <= other requester.
  - Go to APPLY.
- APPLY (cycle T+1):
  - j_out/k_out are registered and valid for this one cycle only; masked bits are 0.
  - The bank updates at the end of T+1.
  - Next state is CHECK.
- CHECK (cycle T+2):
  - Compare q_in with expected. j_out/k_out = 0.
  - On the edge: done<=1, done_id<=id, err<=(q_in!=expected).
  - err_count increments on mismatch and saturates at all-ones.
  - Go to IDLE.
- Cycle T+3: done/err pulse visible; state is IDLE and a new request can be accepted in this same cycle.
- Throughput: one command per 3 cycles. j_out/k_out are 0 in every state except APPLY.
- Valid may drop without ready; no request is queued. Requesters hold cmd/mask stable only in the handshake cycle.
- A mask of all zeros or a hold command still runs the full sequence; done is produced and err=0 if the bank is stable.
- Fairness: with both valid continuously, grants alternate A,B,A,B starting from A after reset. A lone requester is granted back-to-back.

Test Plan:
- Reset with rst=1 for 2 cycles, then a_valid=1, cmd=10, mask=4'b1111, bank at 0000 -> a_ready at T, j_out=1111/k_out=0000 at T+1 only, q_in=1111 at T+2, done=1, done_id=0, err=0 at T+3.
- Both valid continuously with cmd=11, mask=4'b0101 -> grants A,B,A,B every 3 cycles; bank 0000 -> 0101 -> 0000 -> 0101; no err.
- Bank at 1010, B cmd=01, mask=4'b1000 -> j_out=0000, k_out=1000 in APPLY; bank 0010; done_id=1, err=0.
- Bench forces q_in to 0000 during CHECK on a set command with expected 1111 -> err=1 with done; err_count=1. Repeat 300 mismatches -> err_count holds at 255.
- rst asserted during APPLY -> j_out/k_out=0 next cycle, no done, busy=0, next grant goes to A.
- a_valid pulsed for one cycle while busy -> not accepted, no done; mask=0000 with hold -> done with err=0, bank unchanged.
